sat_narrow_32x16: RTL and testbench

//  Narrows 32-bit datapath words to 16-bit halfwords; the inverse of the 16->32 sign-extend path.

---
 rtl/sat_narrow_32x16_pkg.sv | 17 +
 rtl/sat_narrow_32x16_fit.sv | 26 ++
 rtl/sat_narrow_32x16.sv | 143 ++++++++++++++
 tb/tb_sat_narrow_32x16.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sat_narrow_32x16_pkg.sv
// Shared definitions for the 32->16 narrowing block: FSM state codes, mode codes and saturation limits.
package sat_narrow_32x16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_NARROW   = 2'd1,
        ST_SPLIT_LO = 2'd2,
        ST_SPLIT_HI = 2'd3
    } state_e;

    localparam logic MODE_NARROW = 1'b0;
    localparam logic MODE_SPLIT  = 1'b1;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/sat_narrow_32x16_fit.sv
// Combinational signed-fit detect for a 32-bit word, with saturate or truncate on overflow.
module sat_narrow_32x16_fit
    import sat_narrow_32x16_pkg::*;
(
    input  logic [31:0] in_data,
    input  logic        sat_en,
    output logic [15:0] data16,
    output logic        ovf
);

    logic fit_s;

    // The word fits when bits 31..15 are a pure sign extension of bit 15.
    always_comb begin
        fit_s = (in_data[31:15] == 17'h00000) || (in_data[31:15] == 17'h1FFFF);
        ovf   = ~fit_s;
        if (fit_s || !sat_en) begin
            data16 = in_data[15:0];
        end else if (in_data[31] == 1'b0) begin
            data16 = SAT_POS;
        end else begin
            data16 = SAT_NEG;
        end
    end

endmodule

// File: rtl/sat_narrow_32x16.sv
// Narrows 32-bit words to signed halfwords (NARROW) or streams them as two halfword beats (SPLIT).
module sat_narrow_32x16
    import sat_narrow_32x16_pkg::*;
#(
    parameter bit SAT_EN = 1'b1,
    parameter int CNT_W  = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [15:0]      word_hi_r;
    logic             out_valid_r, out_valid_s;
    logic [15:0]      out_data_r, out_data_s;
    logic             out_last_r, out_last_s;
    logic             out_ovf_r, out_ovf_s;
    logic [CNT_W-1:0] ovf_count_r;
    logic [15:0]      fit_data_s;
    logic             fit_ovf_s;
    logic             accept_s, out_hs_s, in_ready_s;

    sat_narrow_32x16_fit u_fit (
        .in_data (in_data),
        .sat_en  (SAT_EN),
        .data16  (fit_data_s),
        .ovf     (fit_ovf_s)
    );

    // A last-beat handshake frees the output register on the same edge a new word lands.
    assign in_ready_s = !reset && (!out_valid_r || (out_ready && out_last_r));
    assign accept_s   = in_valid && in_ready_s;
    assign out_hs_s   = out_valid_r && out_ready;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            word_hi_r   <= 16'h0000;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_last_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_last_r  <= out_last_s;
            out_ovf_r   <= out_ovf_s;
            if (accept_s) begin
                word_hi_r <= in_data[31:16];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_NARROW, ST_SPLIT_HI: begin
                if (accept_s) begin
                    state_s = (in_mode == MODE_SPLIT) ? ST_SPLIT_LO : ST_NARROW;
                end else if (out_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SPLIT_LO: begin
                if (out_hs_s) begin
                    state_s = ST_SPLIT_HI;
                end else begin
                    state_s = ST_SPLIT_LO;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next output-register values; they only move on an acceptance or an output handshake.
    always_comb begin
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_last_s  = out_last_r;
        out_ovf_s   = out_ovf_r;
        if (accept_s) begin
            out_valid_s = 1'b1;
            if (in_mode == MODE_SPLIT) begin
                out_data_s = in_data[15:0];
                out_last_s = 1'b0;
                out_ovf_s  = 1'b0;
            end else begin
                out_data_s = fit_data_s;
                out_last_s = 1'b1;
                out_ovf_s  = fit_ovf_s;
            end
        end else if (out_hs_s) begin
            if (state_r == ST_SPLIT_LO) begin
                out_valid_s = 1'b1;
                out_data_s  = word_hi_r;
                out_last_s  = 1'b1;
                out_ovf_s   = 1'b0;
            end else begin
                out_valid_s = 1'b0;
            end
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // Saturating count of overflowing beats taken by the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_count_r <= {CNT_W{1'b0}};
        end else if (out_hs_s && out_ovf_r && (ovf_count_r != CNT_MAX)) begin
            ovf_count_r <= ovf_count_r + CNT_ONE;
        end else begin
            ovf_count_r <= ovf_count_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_ovf   = out_ovf_r;
    assign ovf_count = ovf_count_r;

endmodule

// File: tb/tb_sat_narrow_32x16.sv
// Scoreboard bench: two instances (saturating and truncating) share stimulus; a monitor checks every beat.
module tb_sat_narrow_32x16;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        ovf;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_mode, out_ready;
    logic [31:0] in_data;
    logic        in_ready_a, out_valid_a, out_last_a, out_ovf_a;
    logic        in_ready_b, out_valid_b, out_last_b, out_ovf_b;
    logic [15:0] out_data_a, out_data_b;
    logic [7:0]  ovf_count_a, ovf_count_b;

    beat_t q_a[$];
    beat_t q_b[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    exp_cnt = 0;
    bit    rnd_ready = 1'b0;

    always #5 clk = ~clk;

    sat_narrow_32x16 #(.SAT_EN(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_last(out_last_a), .out_ovf(out_ovf_a), .ovf_count(ovf_count_a)
    );

    sat_narrow_32x16 #(.SAT_EN(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_last(out_last_b), .out_ovf(out_ovf_b), .ovf_count(ovf_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a word narrows correctly iff its signed value lies in [-32768, 32767].
    function automatic beat_t narrow_ref(input logic [31:0] w, input bit sat);
        beat_t b;
        int v;
        v = $signed(w);
        b.last = 1'b1;
        if (v >= -32768 && v <= 32767) begin
            b.data = w[15:0];
            b.ovf  = 1'b0;
        end else begin
            b.ovf  = 1'b1;
            b.data = sat ? ((v < 0) ? 16'h8000 : 16'h7FFF) : w[15:0];
        end
        return b;
    endfunction

    task automatic push_expected(input logic [31:0] w, input logic m);
        beat_t b;
        if (m) begin
            b.data = w[15:0];  b.last = 1'b0; b.ovf = 1'b0;
            q_a.push_back(b);  q_b.push_back(b);
            b.data = w[31:16]; b.last = 1'b1;
            q_a.push_back(b);  q_b.push_back(b);
        end else begin
            q_a.push_back(narrow_ref(w, 1'b1));
            q_b.push_back(narrow_ref(w, 1'b0));
        end
    endtask

    // Present one word until accepted; tries = cycles spent waiting for in_ready.
    task automatic send(input logic [31:0] w, input logic m, output int tries);
        bit done = 1'b0;
        tries = 0;
        in_valid = 1'b1; in_data = w; in_mode = m;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready_a) begin
                push_expected(w, m);
                done = 1'b1;
            end else begin
                tries++;
            end
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_mode  = 1'($urandom_range(0, 1));
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && q_a.size() != 0; i++) begin
            @(posedge clk); #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("drain_left", q_a.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: every cycle a beat is visible it must match the queue head; pop on handshake.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            q_a.delete();
            q_b.delete();
            exp_cnt = 0;
        end else begin
            if (out_valid_a) begin
                if (q_a.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_beat_a: got data %h last %b, expected none", out_data_a, out_last_a);
                end else begin
                    e = q_a[0];
                    check("data_a", 32'(out_data_a), 32'(e.data));
                    check("last_a", 32'(out_last_a), 32'(e.last));
                    check("ovf_a",  32'(out_ovf_a),  32'(e.ovf));
                    if (!e.last) check("in_ready_mid_split", 32'(in_ready_a), 32'd0);
                    if (out_ready) begin
                        void'(q_a.pop_front());
                        check("ovf_count_a", 32'(ovf_count_a), 32'(exp_cnt));
                        check("ovf_count_b", 32'(ovf_count_b), 32'(exp_cnt));
                        if (e.ovf && exp_cnt < 255) exp_cnt++;
                    end
                end
            end
            if (out_valid_b) begin
                if (q_b.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_beat_b: got data %h, expected none", out_data_b);
                end else begin
                    e = q_b[0];
                    check("data_b", 32'(out_data_b), 32'(e.data));
                    check("last_b", 32'(out_last_b), 32'(e.last));
                    check("ovf_b",  32'(out_ovf_b),  32'(e.ovf));
                    if (out_ready) void'(q_b.pop_front());
                end
            end
        end
    end

    initial begin
        int t;
        logic [31:0] w;
        reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data",  32'(out_data_a),  32'd0);
        check("rst_out_last",  32'(out_last_a),  32'd0);
        check("rst_out_ovf",   32'(out_ovf_a),   32'd0);
        check("rst_ovf_count", 32'(ovf_count_a), 32'd0);
        check("rst_in_ready",  32'(in_ready_a),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;

        // Directed: in-range negative, overflow, split.
        send(32'hFFFF_8000, 1'b0, t);
        send(32'h0001_2345, 1'b0, t);
        send(32'hDEAD_BEEF, 1'b1, t);
        drain();

        // Stall a NARROW beat for 5 cycles with a new word pending.
        out_ready = 1'b0;
        send(32'h0000_1111, 1'b0, t);
        in_valid = 1'b1; in_data = 32'hFFFF_FFFE; in_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready_a), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'hFFFF_FFFE, 1'b0, t);
        check("release_same_edge", 32'(t), 32'd0);
        drain();

        // Back-to-back NARROW stream: every word accepted without waiting.
        for (int i = 0; i < 8; i++) begin
            send($urandom, 1'b0, t);
            check("stream_no_bubble", 32'(t), 32'd0);
        end
        drain();

        // Reset while the high half of a SPLIT is pending.
        send(32'hCAFE_F00D, 1'b1, t);
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_split_valid", 32'(out_valid_a), 32'd0);
        check("rst_split_cnt",   32'(ovf_count_a), 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Randomized mix with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       w = 32'($urandom_range(0, 32767));
                1:       w = 32'h0 - 32'($urandom_range(1, 32768));
                default: w = $urandom;
            endcase
            send(w, 1'($urandom_range(0, 1)), t);
        end
        drain();
        rnd_ready = 1'b0; out_ready = 1'b1;

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            w = {1'b0, 1'b1, 30'($urandom)};
            send(($urandom_range(0, 1) != 0) ? w : ~w, 1'b0, t);
        end
        drain();
        @(negedge clk);
        check("ovf_count_sat_a", 32'(ovf_count_a), 32'h0000_00FF);
        check("ovf_count_sat_b", 32'(ovf_count_b), 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
